// File: rtl/inst_fetch_pkg.sv
// Shared fetch definitions: FSM state encodings, reset PC, NOP encoding.
// Also used by stage1 and the stall/kill logic.
package inst_fetch_pkg;
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    MISS = 2'd2,
    HOLD = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_2000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/inst_fetch_hold_buf.sv
// Single-entry skid register holding the instruction stage1 refused.
module inst_fetch_hold_buf
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        clr_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);
  logic [31:0] inst_q, pc_q;
  logic        valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q  <= NOP_INST_DEF;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      inst_q  <= inst_i;
      pc_q    <= pc_i;
      valid_q <= 1'b1;
    end
  end

  assign inst_o  = inst_q;
  assign pc_o    = pc_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/inst_fetch.sv
// Stage-0 fetch: PC register, I-cache request port, hold buffer, redirect/squash.
// Optional FETCH_MISALIGN_CHECK_EN adds misalign_err for misaligned redirect targets.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] icache_addr,
  output logic        icache_re,
  input  logic [31:0] icache_dout,
  input  logic        icache_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall_in,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        misalign_err
`endif
);
  fetch_state_e state_q, state_d;
  logic [31:0]  req_pc_q, req_pc_d;   // next address to request
  logic [31:0]  out_pc_q, out_pc_d;   // pc of the request whose data is on icache_dout
  logic         out_vld_q, out_vld_d;
  logic         pend_q, pend_d;       // redirect seen during BOOT
  logic [31:0]  pend_pc_q, pend_pc_d;

  logic         redir;
  logic [31:0]  redir_pc, addr_c;
  logic         re_c, vld_c, use_hb, hb_load, hb_clr, hb_vld;
  logic [31:0]  hb_inst, hb_pc;

  assign redir    = (state_q != BOOT) & (redirect_valid | pend_q);
  assign redir_pc = redirect_valid ? redirect_pc : pend_pc_q;

  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    out_pc_d  = out_pc_q;
    out_vld_d = 1'b0;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    addr_c    = req_pc_q;
    re_c      = 1'b1;
    vld_c     = 1'b0;
    use_hb    = 1'b0;
    hb_load   = 1'b0;
    hb_clr    = 1'b0;
    if (redir) begin
      // Current output belongs to the squashed path; never mark it valid.
      addr_c = word_align(redir_pc);
      hb_clr = 1'b1;
      pend_d = 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          addr_c = RESET_PC;
          if (redirect_valid) begin
            pend_d    = 1'b1;
            pend_pc_d = redirect_pc;
          end
        end
        RUN: begin
          vld_c = out_vld_q;
          if (stall_in && out_vld_q) begin
            // Withhold the next request so its data cannot be lost while holding.
            re_c    = 1'b0;
            hb_load = 1'b1;
            state_d = HOLD;
          end
        end
        MISS: ;
        HOLD: begin
          vld_c  = hb_vld;
          use_hb = 1'b1;
          re_c   = ~stall_in;
          hb_clr = ~stall_in;
        end
        default: state_d = BOOT;
      endcase
    end
    if (re_c) begin
      if (icache_stall) begin
        state_d  = MISS;
        req_pc_d = addr_c;
      end else begin
        state_d   = RUN;
        out_pc_d  = addr_c;
        out_vld_d = 1'b1;
        req_pc_d  = addr_c + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BOOT;
      req_pc_q  <= RESET_PC;
      out_pc_q  <= RESET_PC;
      out_vld_q <= 1'b0;
      pend_q    <= 1'b0;
      pend_pc_q <= RESET_PC;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      out_pc_q  <= out_pc_d;
      out_vld_q <= out_vld_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  inst_fetch_hold_buf #(.RESET_PC(RESET_PC)) u_hold (
    .clk     (clk),
    .rst     (reset),
    .load_i  (hb_load),
    .clr_i   (hb_clr),
    .inst_i  (icache_dout),
    .pc_i    (out_pc_q),
    .inst_o  (hb_inst),
    .pc_o    (hb_pc),
    .valid_o (hb_vld)
  );

  assign icache_addr = addr_c;
  assign icache_re   = re_c & ~reset;
  assign inst_valid  = vld_c;
  assign inst        = vld_c ? (use_hb ? hb_inst : icache_dout) : NOP_INST;
  assign inst_pc     = use_hb ? hb_pc : out_pc_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic mis_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mis_q <= 1'b0;
    else       mis_q <= redir & (|redir_pc[1:0]);
  end
  assign misalign_err = mis_q;
`else
  logic unused_pc_lo;
  assign unused_pc_lo = ^redir_pc[1:0];
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed vector table, corner sequences, random run vs program-order model.
module tb_inst_fetch;
  localparam logic [31:0] RPC = 32'h0000_2000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0, reset = 1'b1;
  logic [31:0] icache_addr, icache_dout, redirect_pc, inst, inst_pc;
  logic        icache_re, icache_stall, redirect_valid, stall_in, inst_valid;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif
  int checks = 0, failures = 0;

  inst_fetch dut (
    .clk(clk), .reset(reset), .icache_addr(icache_addr), .icache_re(icache_re),
    .icache_dout(icache_dout), .icache_stall(icache_stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_in(stall_in),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC0DE_0000;
  endfunction

  // Cache model: 1-cycle latency on accepted requests, garbage otherwise.
  always @(posedge clk)
    if (icache_re && !icache_stall) icache_dout <= mem_f(icache_addr);
    else                            icache_dout <= $urandom;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic si, input logic is, input logic rv, input logic [31:0] rpc);
    stall_in = si; icache_stall = is; redirect_valid = rv; redirect_pc = rpc;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  typedef struct {
    logic si, is, rv;
    logic [31:0] rpc, e_addr;
    logic e_re, e_vld;
    logic [31:0] e_pc;
    logic e_mis;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic si, is, rv, input logic [31:0] rpc, ea,
                     input logic er, ev, input logic [31:0] ep, input logic em = 1'b0);
    vec_t v;
    v.si = si; v.is = is; v.rv = rv; v.rpc = rpc; v.e_addr = ea;
    v.e_re = er; v.e_vld = ev; v.e_pc = ep; v.e_mis = em;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] exp_pc, prev_pc;
    logic        prev_hold, exp_mis;
    int          delivered;

    drive(0, 0, 0, 0);
    #12;
    chk("rst_re", {31'd0, icache_re}, 0);
    chk("rst_addr", icache_addr, RPC);
    chk("rst_inst", inst, NOP);
    chk("rst_pc", inst_pc, RPC);
    chk("rst_vld", {31'd0, inst_valid}, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_mis", {31'd0, misalign_err}, 0);
`endif

    //    si is rv rpc           addr          re vld pc
    add(0, 0, 0, 0,            32'h2000,     1, 0, 0);
    add(0, 0, 0, 0,            32'h2004,     1, 1, 32'h2000);
    add(0, 1, 0, 0,            32'h2008,     1, 1, 32'h2004);
    add(0, 1, 0, 0,            32'h2008,     1, 0, 0);
    add(0, 1, 0, 0,            32'h2008,     1, 0, 0);
    add(0, 0, 0, 0,            32'h2008,     1, 0, 0);
    add(0, 0, 0, 0,            32'h200C,     1, 1, 32'h2008);
    add(1, 0, 0, 0,            32'h2010,     0, 1, 32'h200C);
    add(1, 0, 0, 0,            32'h2010,     0, 1, 32'h200C);
    add(0, 0, 0, 0,            32'h2010,     1, 1, 32'h200C);
    add(0, 0, 1, 32'h3000,     32'h3000,     1, 0, 0);
    add(0, 0, 0, 0,            32'h3004,     1, 1, 32'h3000);
    add(0, 1, 0, 0,            32'h3008,     1, 1, 32'h3004);
    add(0, 1, 1, 32'h4000,     32'h4000,     1, 0, 0);
    add(0, 0, 0, 0,            32'h4000,     1, 0, 0);
    add(0, 0, 0, 0,            32'h4004,     1, 1, 32'h4000);
    add(1, 0, 1, 32'h5000,     32'h5000,     1, 0, 0);
    add(1, 0, 0, 0,            32'h5004,     0, 1, 32'h5000);
    add(1, 0, 1, 32'h6000,     32'h6000,     1, 0, 0);
    add(0, 0, 0, 0,            32'h6004,     1, 1, 32'h6000);
    add(0, 0, 1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1, 0, 0);
    add(0, 0, 0, 0,            32'h0,        1, 1, 32'hFFFFFFFC);
    add(0, 0, 0, 0,            32'h4,        1, 1, 32'h0);
    add(0, 0, 1, 32'h3002,     32'h3000,     1, 0, 0);
    add(0, 0, 0, 0,            32'h3004,     1, 1, 32'h3000, 1'b1);
    add(0, 1, 0, 0,            32'h3008,     1, 1, 32'h3004);
    add(1, 0, 0, 0,            32'h3008,     1, 0, 0);
    add(0, 0, 0, 0,            32'h300C,     1, 1, 32'h3008);

    @(posedge clk); #1 reset = 1'b0;
    foreach (vecs[i]) begin
      drive(vecs[i].si, vecs[i].is, vecs[i].rv, vecs[i].rpc);
      @(negedge clk);
      chk($sformatf("v%0d_addr", i), icache_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_re", i), {31'd0, icache_re}, {31'd0, vecs[i].e_re});
      chk($sformatf("v%0d_vld", i), {31'd0, inst_valid}, {31'd0, vecs[i].e_vld});
      chk($sformatf("v%0d_inst", i), inst, vecs[i].e_vld ? mem_f(vecs[i].e_pc) : NOP);
      if (vecs[i].e_vld) chk($sformatf("v%0d_pc", i), inst_pc, vecs[i].e_pc);
`ifdef FETCH_MISALIGN_CHECK_EN
      chk($sformatf("v%0d_mis", i), {31'd0, misalign_err}, {31'd0, vecs[i].e_mis});
`endif
      @(posedge clk); #1;
    end

    // Reset asserted in the middle of a miss.
    drive(0, 1, 0, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mm_addr_held", icache_addr, 32'h3010);
    #1 reset = 1'b1;
    #1;
    chk("mm_rst_re", {31'd0, icache_re}, 0);
    chk("mm_rst_addr", icache_addr, RPC);
    chk("mm_rst_vld", {31'd0, inst_valid}, 0);
    chk("mm_rst_inst", inst, NOP);
    chk("mm_rst_pc", inst_pc, RPC);
    @(posedge clk); #1 reset = 1'b0;
    drive(0, 0, 0, 0);
    @(negedge clk);
    chk("mm_boot_addr", icache_addr, RPC);
    chk("mm_boot_re", {31'd0, icache_re}, 1);
    @(posedge clk); #1; @(negedge clk);
    chk("mm_first_vld", {31'd0, inst_valid}, 1);
    chk("mm_first_pc", inst_pc, RPC);
    chk("mm_first_inst", inst, mem_f(RPC));

    // Redirect arriving during BOOT is applied on exit.
    do_reset();
    drive(0, 0, 1, 32'h7000);
    @(negedge clk);
    chk("bt_addr", icache_addr, RPC);
    @(posedge clk); #1 drive(0, 0, 0, 0);
    @(negedge clk);
    chk("bt_redir_addr", icache_addr, 32'h7000);
    chk("bt_squash", {31'd0, inst_valid}, 0);
    @(posedge clk); #1; @(negedge clk);
    chk("bt_tgt_vld", {31'd0, inst_valid}, 1);
    chk("bt_tgt_pc", inst_pc, 32'h7000);

    // Random run: delivered stream must follow program order from the model.
    do_reset();
    exp_pc = RPC; prev_hold = 0; prev_pc = 0; exp_mis = 0; delivered = 0;
    for (int c = 0; c < 2000; c++) begin
      drive($urandom_range(3) == 0, $urandom_range(3) == 0,
            (c != 0) && ($urandom_range(19) == 0), $urandom);
      @(negedge clk);
      if (icache_addr[1:0] != 2'b00) chk("rnd_align", icache_addr, {icache_addr[31:2], 2'b00});
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("rnd_mis", {31'd0, misalign_err}, {31'd0, exp_mis});
`endif
      if (prev_hold && !redirect_valid) begin
        chk("rnd_hold_vld", {31'd0, inst_valid}, 1);
        chk("rnd_hold_pc", inst_pc, prev_pc);
      end
      if (inst_valid) chk("rnd_data", inst, mem_f(inst_pc));
      if (inst_valid && !stall_in && !redirect_valid) begin
        chk("rnd_order", inst_pc, exp_pc);
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
      exp_mis   = redirect_valid && (redirect_pc[1:0] != 2'b00);
      prev_hold = inst_valid && stall_in && !redirect_valid;
      prev_pc   = inst_pc;
      @(posedge clk); #1;
    end
    chk("rnd_progress", {31'd0, delivered >= 200}, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
